// File: rtl/multilane_serializer.sv
// Multi-lane parallel-to-serial converter. Each lane has a shift register, and all lanes share one word buffer.
// Words are framed on a common bit clock. When no data is available, IDLE_WORD is sent as fill.
module multilane_serializer #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      LANES     = 1,
    parameter int unsigned      DIV       = 1,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH*LANES-1:0] data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [LANES-1:0]       data_o,
    output logic                   frame_o,
    output logic                   idle_o
);

    localparam int unsigned     PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned     BW       = $clog2(WIDTH);
    localparam int unsigned     TW       = WIDTH * LANES;
    localparam int unsigned     OUT_BIT  = MSB_FIRST ? WIDTH - 1 : 0;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
    localparam logic [TW-1:0]   IDLE_ALL = {LANES{IDLE_WORD}};

    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic          buf_full_q, buf_full_d;
    logic [TW-1:0] buf_q, buf_d;
    logic [TW-1:0] shreg_q, shreg_d;
    logic          idle_q, idle_d;

    logic bit_edge;
    logic load_edge;
    logic hs;

    assign bit_edge  = (presc_q == PRE_LAST);
    assign load_edge = bit_edge && (bitcnt_q == BIT_LAST);
    assign ready_o   = !buf_full_q || load_edge;
    assign hs        = valid_i && ready_o;

    // The bit counter holds 0 exactly for the DIV cycles after a load edge.
    // Reset parks the counter at WIDTH-1, so frame_o stays low until the first load.
    assign frame_o = (bitcnt_q == '0);
    assign idle_o  = idle_q;

    always_comb begin
        data_o = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            data_o[l] = shreg_q[l*WIDTH + OUT_BIT];
        end
    end

    always_comb begin
        presc_d    = bit_edge ? '0 : presc_q + 1'b1;
        bitcnt_d   = bitcnt_q;
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        shreg_d    = shreg_q;
        idle_d     = idle_q;

        if (bit_edge) begin
            bitcnt_d = load_edge ? '0 : bitcnt_q + 1'b1;
        end

        if (load_edge) begin
            if (buf_full_q) begin
                shreg_d    = buf_q;
                idle_d     = 1'b0;
                buf_full_d = hs;
                if (hs) begin
                    buf_d = data_i;
                end
            end else if (hs) begin
                shreg_d = data_i;
                idle_d  = 1'b0;
            end else begin
                shreg_d = IDLE_ALL;
                idle_d  = 1'b1;
            end
        end else begin
            if (bit_edge) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    if (MSB_FIRST) begin
                        shreg_d[l*WIDTH +: WIDTH] = {shreg_q[l*WIDTH +: WIDTH-1], 1'b0};
                    end else begin
                        shreg_d[l*WIDTH +: WIDTH] = {1'b0, shreg_q[l*WIDTH+1 +: WIDTH-1]};
                    end
                end
            end
            // On a non-load edge a handshake can only occur while the buffer is empty.
            if (hs) begin
                buf_d      = data_i;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= PRE_LAST;
            bitcnt_q   <= BIT_LAST;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            shreg_q    <= IDLE_ALL;
            idle_q     <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            bitcnt_q   <= bitcnt_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            shreg_q    <= shreg_d;
            idle_q     <= idle_d;
        end
    end

endmodule

// File: tb/tb_multilane_serializer.sv
// Self-checking bench for multilane_serializer. It runs three configurations (MSB-first, LSB-first, DIV=3)
// and checks them against a word-queue reference model driven by random and directed stimulus.
module tb_multilane_serializer;

    localparam int W = 16;
    localparam int L = 2;
    localparam int N = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [W*L-1:0] din  [N];
    logic           vin  [N];
    logic           rdy  [N];
    logic [L-1:0]   dout [N];
    logic           frm  [N];
    logic           idl  [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multilane_serializer #(.WIDTH(W), .LANES(L), .DIV(1), .MSB_FIRST(1'b1), .IDLE_WORD(16'h0000)) u_msb (
        .clk(clk), .reset(reset), .data_i(din[0]), .valid_i(vin[0]), .ready_o(rdy[0]),
        .data_o(dout[0]), .frame_o(frm[0]), .idle_o(idl[0]));

    multilane_serializer #(.WIDTH(W), .LANES(L), .DIV(1), .MSB_FIRST(1'b0), .IDLE_WORD(16'h0000)) u_lsb (
        .clk(clk), .reset(reset), .data_i(din[1]), .valid_i(vin[1]), .ready_o(rdy[1]),
        .data_o(dout[1]), .frame_o(frm[1]), .idle_o(idl[1]));

    multilane_serializer #(.WIDTH(W), .LANES(L), .DIV(3), .MSB_FIRST(1'b1), .IDLE_WORD(16'h0000)) u_div3 (
        .clk(clk), .reset(reset), .data_i(din[2]), .valid_i(vin[2]), .ready_o(rdy[2]),
        .data_o(dout[2]), .frame_o(frm[2]), .idle_o(idl[2]));

    // Reference model: accepted-but-unsent words wait in a queue, and each instance owns one word slot.
    // A slot lasts W*DIV cycles. The slot timer starts on the first edge after reset is released.
    logic [W*L-1:0] pend [N][$];
    logic [W*L-1:0] cur_w   [N];
    logic           cur_idle[N];
    int             k       [N];
    int             j       [N];
    int             n_acc   [N];
    bit             in_rst;

    function automatic int div_of(int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic bit msbf_of(int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic bit slot_start(int i);
        return !in_rst && (k[i] % (W * div_of(i)) == 0);
    endfunction

    function automatic logic exp_ready(int i);
        return (pend[i].size() == 0) || slot_start(i);
    endfunction

    function automatic logic [L-1:0] exp_data(int i);
        logic [L-1:0] r;
        logic [W-1:0] lw;
        int b;
        r = '0;
        if (j[i] >= 0) begin
            b = j[i] / div_of(i);
            for (int l = 0; l < L; l++) begin
                lw   = cur_w[i][l*W +: W];
                r[l] = lw[msbf_of(i) ? (W - 1 - b) : b];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        in_rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            cur_w[i]    = '0;
            cur_idle[i] = 1'b1;
            k[i]        = 0;
            j[i]        = -1;
        end
    endtask

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst%0d t=%0t observed=%h expected=%h", tag, i, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk("data_o",  i, 32'(dout[i]), 32'(exp_data(i)));
            chk("frame_o", i, 32'(frm[i]),  32'(j[i] >= 0 && j[i] < div_of(i)));
            chk("idle_o",  i, 32'(idl[i]),  32'(cur_idle[i]));
            chk("ready_o", i, 32'(rdy[i]),  32'(exp_ready(i)));
        end
    endtask

    task automatic tick();
        bit acc [N];
        bit ld  [N];
        for (int i = 0; i < N; i++) begin
            acc[i] = vin[i] && exp_ready(i) && !in_rst;
            ld[i]  = slot_start(i);
        end
        @(posedge clk);
        if (!in_rst) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    pend[i].push_back(din[i]);
                    n_acc[i]++;
                end
                if (ld[i]) begin
                    if (pend[i].size() != 0) begin
                        cur_w[i]    = pend[i].pop_front();
                        cur_idle[i] = 1'b0;
                    end else begin
                        cur_w[i]    = '0;
                        cur_idle[i] = 1'b1;
                    end
                    j[i] = 0;
                end else if (j[i] >= 0) begin
                    j[i]++;
                end
                k[i]++;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    // Called just after a negedge, so reset rises mid-cycle and its effect is checked before any clock edge.
    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        reset  = 1'b0;
        in_rst = 1'b0;
    endtask

    initial begin
        int base [N];
        for (int i = 0; i < N; i++) begin
            vin[i]   = 1'b0;
            din[i]   = '0;
            n_acc[i] = 0;
        end
        model_reset();

        // Reset held, then released with no data: idle fill with periodic frames
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        reset  = 1'b0;
        in_rst = 1'b0;
        repeat (40) tick();

        // Single word handshaken on the first post-reset edge
        apply_reset();
        for (int i = 0; i < N; i++) begin
            vin[i] = 1'b1;
            din[i] = 32'h0001_A5C3;
        end
        tick();
        for (int i = 0; i < N; i++) vin[i] = 1'b0;
        repeat (60) tick();

        // Random traffic
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                vin[i] = ($urandom_range(0, 3) != 0);
                din[i] = $urandom;
            end
            tick();
        end

        // Continuous valid with incrementing words
        for (int i = 0; i < N; i++) vin[i] = 1'b0;
        repeat (60) tick();
        repeat (160) begin
            for (int i = 0; i < N; i++) begin
                vin[i] = 1'b1;
                din[i] = {16'(n_acc[i] + 32'h1000), 16'(n_acc[i])};
            end
            tick();
        end

        // Two words then stop: the third slot must be idle fill
        for (int i = 0; i < N; i++) vin[i] = 1'b0;
        apply_reset();
        for (int i = 0; i < N; i++) base[i] = n_acc[i];
        repeat (150) begin
            for (int i = 0; i < N; i++) begin
                vin[i] = (n_acc[i] - base[i] < 2);
                din[i] = {16'h5A00 ^ 16'(n_acc[i]), 16'hC300 ^ 16'(n_acc[i])};
            end
            tick();
        end

        // Word 16'h8001 at DIV=3 interrupted by reset at bit 5
        for (int i = 0; i < N; i++) vin[i] = 1'b0;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            vin[i] = 1'b1;
            din[i] = 32'h8001_8001;
        end
        tick();
        for (int i = 0; i < N; i++) vin[i] = 1'b0;
        repeat (15) tick();
        apply_reset();
        repeat (100) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multilane_serializer.md
MULTILANE_SERIALIZER -- requirements
Module: multilane_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per word per lane (>=2).
REQ-002 SHALL have parameter LANES, default 1, meaning number of parallel serial lanes (>=1).
REQ-003 SHALL have parameter DIV, default 1, meaning clk cycles per serial bit (>=1).
REQ-004 SHALL have parameter MSB_FIRST, default 1, meaning 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-005 SHALL have parameter IDLE_WORD, default '0, meaning the WIDTH-bit fill word sent on every lane when no data is available.
REQ-006 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port data_i  input  WIDTH*LANES  parallel word; lane l takes data_i[l*WIDTH +: WIDTH].
REQ-009 SHALL have port valid_i  input  1  data_i valid.
REQ-010 SHALL have port ready_o  output  1  block can accept data_i this cycle.
REQ-011 SHALL have port data_o  output  LANES  serial bit per lane.
REQ-012 SHALL have port frame_o  output  1  high while data_o carries the first bit of a word.
REQ-013 SHALL have port idle_o  output  1  high while the word being shifted is IDLE_WORD fill.

Function
REQ-014 SHALL contain a prescaler counting 0..DIV-1; a bit edge is the clk edge where prescaler = DIV-1 (every edge when DIV=1).
REQ-015 SHALL contain a bit counter 0..WIDTH-1 advancing (with wrap to 0) only on bit edges; a load edge is a bit edge with bit counter = WIDTH-1.
REQ-016 SHALL hold one shift register per lane; on non-load bit edges each shifts by one toward the output end selected by MSB_FIRST.
REQ-017 SHALL drive data_o[l] directly from lane l's shift-register output bit (no combinational path from data_i).
REQ-018 SHALL hold a one-entry word buffer (all lanes); handshake completes on any clk edge with valid_i and ready_o both high.
REQ-019 SHALL drive ready_o = buffer empty OR current edge is a load edge.
REQ-020 On a load edge with buffer full, SHALL load the buffered word into the shift registers; a simultaneous handshake writes the new word into the buffer, otherwise buffer becomes empty.
REQ-021 On a load edge with buffer empty and handshake, SHALL load data_i directly into the shift registers (bypass), buffer stays empty.
REQ-022 On a load edge with buffer empty and no handshake, SHALL load IDLE_WORD into every lane (underrun) and set idle_o=1 for that word; loading real data sets idle_o=0.
REQ-023 On a non-load edge handshake with buffer empty, SHALL write data_i into the buffer.
REQ-024 SHALL assert frame_o for exactly the DIV clk cycles following each load edge.
REQ-025 Each bit SHALL be held on data_o for exactly DIV clk cycles; consecutive words SHALL follow with no gap bits.
REQ-026 Data and bits accepted SHALL never be dropped or duplicated; ready_o low with valid_i high SHALL leave data_i unconsumed.

Reset
REQ-027 While reset is high: prescaler = DIV-1, bit counter = WIDTH-1, buffer empty, shift registers = IDLE_WORD, idle_o=1, frame_o=0, ready_o=1, data_o = IDLE_WORD first bit per MSB_FIRST.
REQ-028 The first rising clk edge after reset deasserts SHALL be a load edge.
REQ-029 Reset asserted mid-word SHALL discard the shifting word and buffered word immediately (asynchronously) with no partial word emitted after release.

Verification (WIDTH=16, LANES=2, DIV=1, MSB_FIRST=1, IDLE_WORD=0 unless stated)
REQ-030 Reset held -> data_o=2'b00, frame_o=0, idle_o=1, ready_o=1; release with valid_i=0 -> data_o stays 0, frame_o pulses every 16 cycles, idle_o=1.
REQ-031 Single handshake data_i={16'h0001,16'hA5C3} on first post-reset edge -> lane0 emits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over next 16 cycles, lane1 fifteen 0s then 1, frame_o on first cycle, idle_o=0, then idle fill.
REQ-032 valid_i held high with incrementing words -> ready_o low except on load edges after buffer fills; output words contiguous, no gaps, no drops, frame_o every 16 cycles.
REQ-033 Stop valid_i after 2 words -> third word slot is IDLE_WORD with idle_o=1 and frame_o still asserted at its start.
REQ-034 MSB_FIRST=0, data 16'hA5C3 -> lane0 emits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
REQ-035 DIV=3, word 16'h8001, assert reset for 1 cycle at bit 5 -> each bit held 3 cycles before reset; after reset outputs idle values, first load on first edge after release, no remaining bits of 16'h8001 appear.
